// File: rtl/ug_truth_checker.sv
// Built-in self-test for the universal-gate NAND block: walks {a,b} through all four
// vectors, samples AND/OR/NOT after a settle delay and reports errors.
module ug_truth_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             nand_and,
  input  logic             nand_or,
  input  logic             nand_not,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [7:0] loop_cnt;
  logic       mismatch;
  logic       sample_now;
  logic       last_vec;

  // A vector is one error no matter how many of the three outputs disagree.
  assign mismatch   = (nand_and != (a & b)) || (nand_or != (a | b)) || (nand_not != ~a);
  assign sample_now = (settle_cnt == SETTLE_LAST);
  assign last_vec   = a & b & (loop_cnt == LOOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
      settle_cnt <= '0;
      loop_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            {a, b}     <= 2'b00;
            err_cnt    <= '0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
            settle_cnt <= '0;
            loop_cnt   <= '0;
          end
        end
        RUN: begin
          if (sample_now) begin
            settle_cnt <= '0;
            if (mismatch) begin
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= {a, b};
              end
            end
            // fail_valid still reflects earlier vectors only, so fold in this sample too.
            if (last_vec) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              {a, b} <= 2'b00;
              pass   <= !(fail_valid || mismatch);
            end else begin
              {a, b} <= {a, b} + 2'b01;
              if (a & b) loop_cnt <= loop_cnt + 8'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
